if_stage: RTL and testbench
===========================

IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 SHALL provide parameter RESET_PC, default 16'h0000, first fetch address after reset.
REQ-002 SHALL provide parameter NOP_INSTR, default 16'h0000, bubble instruction value driven to decode.
REQ-003 SHALL have port i_clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port i_nRst  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port i_stall  input  1  decode hazard; hold PC and IF/ID register.
REQ-006 SHALL have port i_brTaken  input  1  resolved branch/jump taken; redirect fetch.
REQ-007 SHALL have port i_brTarget  input  16  redirect address, valid with i_brTaken.
REQ-008 SHALL have port i_hlt  input  1  halt decoded downstream.
REQ-009 SHALL have port o_imemAddr  output  16  instruction memory word address.
REQ-010 SHALL have port o_imemRd  output  1  instruction memory read request.
REQ-011 SHALL have port i_imemData  input  16  fetched instruction, valid when i_imemRdy=1.
REQ-012 SHALL have port i_imemRdy  input  1  memory returns data for o_imemAddr this cycle.
REQ-013 SHALL have port o_instr  output  16  IF/ID instruction to decode stage.
REQ-014 SHALL have port o_pc  output  16  IF/ID address of o_instr plus 1.
REQ-015 SHALL have port o_valid  output  1  o_instr is a real instruction (0 = bubble).
REQ-016 SHALL have port o_hlt  output  1  fetch halted.

Function
REQ-017 SHALL hold a 16-bit word-addressed PC; o_imemAddr = PC combinationally.
REQ-018 SHALL implement FSM states RUN, WAIT, HALT; o_imemRd=1 in RUN and WAIT, 0 in HALT.
REQ-019 SHALL apply per-cycle priority: reset > i_brTaken > i_hlt > i_stall > memory response.
REQ-020 SHALL, on i_brTaken in RUN/WAIT: PC<=i_brTarget, IF/ID<=bubble, state<=RUN, discard any i_imemData that cycle.
REQ-021 SHALL, on i_hlt without i_brTaken: state<=HALT, IF/ID<=bubble, PC frozen; HALT exits only by reset (i_brTaken ignored in HALT).
REQ-022 SHALL, on i_stall (no redirect/halt): hold PC, IF/ID and state unchanged, ignore i_imemData.
REQ-023 SHALL, on i_imemRdy=1 otherwise: o_instr<=i_imemData, o_pc<=PC+1, o_valid<=1, PC<=PC+1, state<=RUN (one-cycle fetch latency).
REQ-024 SHALL, on i_imemRdy=0 otherwise: IF/ID<=bubble, PC held, state<=WAIT.
REQ-025 SHALL define bubble as o_instr=NOP_INSTR, o_valid=0, o_pc unchanged.
REQ-026 SHALL wrap PC+1 modulo 2^16 (16'hFFFF -> 16'h0000) with no flag.
REQ-027 SHALL drive o_hlt=1 exactly when state is HALT.

Reset
REQ-028 SHALL, with i_nRst=0 at a clock edge, set PC=RESET_PC, state=RUN, o_instr=NOP_INSTR, o_pc=16'h0000, o_valid=0, o_hlt=0, overriding all other inputs including mid-WAIT and HALT.
REQ-029 SHALL issue the first read of RESET_PC in the first cycle after reset deasserts.

Configuration
REQ-030 SHALL, when IF_STALL_CNT_EN is defined, add output o_stallCnt (16) counting cycles in WAIT or with i_stall=1 while not HALT, cleared by reset, saturating at 16'hFFFF.
REQ-031 SHALL, when IF_STALL_CNT_EN is undefined, omit o_stallCnt and the counter with otherwise identical behaviour.

Verification
REQ-032 SHALL test sequential fetch: reset, i_imemRdy=1 constant, data 16'h1111,16'h2222 -> o_instr 1111/o_pc 0001 then 2222/0002, o_valid=1.
REQ-033 SHALL test redirect: i_brTaken=1, i_brTarget=16'h0040 at PC=0005 -> next o_imemAddr=0040, o_valid=0 that cycle, then instr from 0040 with o_pc=0041.
REQ-034 SHALL test stall: i_stall=1 for 3 cycles at PC=0010 -> o_imemAddr stays 0010, o_instr/o_valid unchanged; fetch resumes after release.
REQ-035 SHALL test memory wait: i_imemRdy=0 for 2 cycles -> two bubbles, PC held, state WAIT; i_brTaken during WAIT -> redirect wins.
REQ-036 SHALL test halt: i_hlt=1 -> o_hlt=1, o_imemRd=0 next cycle, later i_brTaken ignored; i_hlt with i_brTaken same cycle -> redirect, o_hlt=0.
REQ-037 SHALL test wrap and reset: PC=FFFF fetch -> o_pc=0000, next address 0000; i_nRst=0 mid-WAIT -> all outputs at reset values; with IF_STALL_CNT_EN, 3 stall cycles -> o_stallCnt=3.

Source files
------------

// File: rtl/if_stage.sv
// Instruction fetch stage: PC register, RUN/WAIT/HALT fetch FSM and IF/ID pipeline register.
// Optional stall-cycle counter is enabled by defining IF_STALL_CNT_EN.
module if_stage #(
  parameter logic [15:0] RESET_PC  = 16'h0000,
  parameter logic [15:0] NOP_INSTR = 16'h0000
) (
  input  logic        i_clk,
  input  logic        i_nRst,
  input  logic        i_stall,
  input  logic        i_brTaken,
  input  logic [15:0] i_brTarget,
  input  logic        i_hlt,
  output logic [15:0] o_imemAddr,
  output logic        o_imemRd,
  input  logic [15:0] i_imemData,
  input  logic        i_imemRdy,
  output logic [15:0] o_instr,
  output logic [15:0] o_pc,
  output logic        o_valid,
  output logic        o_hlt
`ifdef IF_STALL_CNT_EN
  ,
  output logic [15:0] o_stallCnt
`endif
);

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    WAIT = 2'd1,
    HALT = 2'd2
  } state_t;

  state_t      state_reg, state_next;
  logic [15:0] pc_reg, pc_next;
  logic [15:0] instr_reg, instr_next;
  logic [15:0] npc_reg, npc_next;
  logic        valid_reg, valid_next;

  // Priority inside a live state: redirect > halt > stall > memory response.
  always_comb begin
    state_next = state_reg;
    pc_next    = pc_reg;
    instr_next = instr_reg;
    npc_next   = npc_reg;
    valid_next = valid_reg;
    if (state_reg != HALT) begin
      if (i_brTaken) begin
        pc_next    = i_brTarget;
        instr_next = NOP_INSTR;
        valid_next = 1'b0;
        state_next = RUN;
      end else if (i_hlt) begin
        instr_next = NOP_INSTR;
        valid_next = 1'b0;
        state_next = HALT;
      end else if (i_stall) begin
        state_next = state_reg;
      end else if (i_imemRdy) begin
        instr_next = i_imemData;
        npc_next   = pc_reg + 16'd1;
        valid_next = 1'b1;
        pc_next    = pc_reg + 16'd1;
        state_next = RUN;
      end else begin
        instr_next = NOP_INSTR;
        valid_next = 1'b0;
        state_next = WAIT;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_nRst) begin
      state_reg <= RUN;
      pc_reg    <= RESET_PC;
      instr_reg <= NOP_INSTR;
      npc_reg   <= 16'h0000;
      valid_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      pc_reg    <= pc_next;
      instr_reg <= instr_next;
      npc_reg   <= npc_next;
      valid_reg <= valid_next;
    end
  end

  assign o_imemAddr = pc_reg;
  assign o_imemRd   = (state_reg != HALT);
  assign o_hlt      = (state_reg == HALT);
  assign o_instr    = instr_reg;
  assign o_pc       = npc_reg;
  assign o_valid    = valid_reg;

`ifdef IF_STALL_CNT_EN
  logic [15:0] stall_cnt_reg;
  logic        stall_cycle;

  // A lost fetch cycle is either a memory wait or a decode hazard, never while halted.
  assign stall_cycle = (state_reg != HALT) && ((state_reg == WAIT) || i_stall);

  always_ff @(posedge i_clk) begin
    if (!i_nRst) begin
      stall_cnt_reg <= 16'h0000;
    end else if (stall_cycle && (stall_cnt_reg != 16'hFFFF)) begin
      stall_cnt_reg <= stall_cnt_reg + 16'd1;
    end
  end

  assign o_stallCnt = stall_cnt_reg;
`endif

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a behavioural fetch model.
module tb_if_stage;
  localparam logic [15:0] NOP = 16'hE000;

  logic        clk = 1'b0;
  logic        nrst, stall, br, hlt, rdy;
  logic [15:0] tgt, data;
  logic [15:0] o_imemAddr, o_instr, o_pc;
  logic        o_imemRd, o_valid, o_hlt;
`ifdef IF_STALL_CNT_EN
  logic [15:0] o_stallCnt;
`endif

  always #5 clk = ~clk;

  if_stage #(.RESET_PC(16'h0000), .NOP_INSTR(NOP)) dut (
    .i_clk(clk), .i_nRst(nrst), .i_stall(stall), .i_brTaken(br),
    .i_brTarget(tgt), .i_hlt(hlt), .o_imemAddr(o_imemAddr), .o_imemRd(o_imemRd),
    .i_imemData(data), .i_imemRdy(rdy), .o_instr(o_instr), .o_pc(o_pc),
    .o_valid(o_valid), .o_hlt(o_hlt)
`ifdef IF_STALL_CNT_EN
    , .o_stallCnt(o_stallCnt)
`endif
  );

  int n_vec = 0;
  int n_miss = 0;

  // Model: what the fetch stage must present, derived from the behavioural rules.
  logic [15:0] m_pc, m_instr, m_opc, m_cnt;
  logic        m_valid, m_halt, m_wait;
  bit          check_en = 0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    if (!nrst) begin
      m_pc = 16'h0000; m_instr = NOP; m_opc = 16'h0000;
      m_valid = 0; m_halt = 0; m_wait = 0; m_cnt = 16'h0000;
    end else if (!m_halt) begin
      if ((m_wait || stall) && m_cnt != 16'hFFFF) m_cnt = m_cnt + 1;
      if (br) begin
        m_pc = tgt; m_instr = NOP; m_valid = 0; m_wait = 0;
      end else if (hlt) begin
        m_halt = 1; m_instr = NOP; m_valid = 0;
      end else if (stall) begin
        // everything frozen
      end else if (rdy) begin
        m_instr = data; m_opc = m_pc + 1; m_valid = 1; m_pc = m_pc + 1; m_wait = 0;
      end else begin
        m_instr = NOP; m_valid = 0; m_wait = 1;
      end
    end
  endtask

  task automatic cyc(input logic n, input logic s, input logic b, input logic [15:0] t,
                     input logic h, input logic r, input logic [15:0] d);
    nrst = n; stall = s; br = b; tgt = t; hlt = h; rdy = r; data = d;
    @(posedge clk);
    model_step();
    #1;
  endtask

  always @(negedge clk) begin
    if (check_en) begin
      chk("imemAddr", o_imemAddr, m_pc);
      chk("imemRd", {15'd0, o_imemRd}, {15'd0, !m_halt});
      chk("hlt", {15'd0, o_hlt}, {15'd0, m_halt});
      chk("instr", o_instr, m_instr);
      chk("pc", o_pc, m_opc);
      chk("valid", {15'd0, o_valid}, {15'd0, m_valid});
`ifdef IF_STALL_CNT_EN
      chk("stallCnt", o_stallCnt, m_cnt);
`endif
    end
  end

  initial begin
    logic n, s, b, h, r;
    logic [15:0] t;
    // Reset with every other input asserted to prove reset overrides them.
    cyc(0, 1, 1, 16'h1234, 1, 1, 16'hFFFF);
    check_en = 1;
    cyc(0, 0, 0, 16'h0000, 0, 1, 16'h0000);
    chk("rst_addr", o_imemAddr, 16'h0000);
    chk("rst_valid", {15'd0, o_valid}, 16'h0000);
    chk("rst_instr", o_instr, NOP);
    chk("rst_pc", o_pc, 16'h0000);
    chk("rst_hlt", {15'd0, o_hlt}, 16'h0000);
    chk("rst_rd", {15'd0, o_imemRd}, 16'h0001);

    // Sequential fetch
    cyc(1, 0, 0, 16'h0, 0, 1, 16'h1111);
    chk("seq1_instr", o_instr, 16'h1111);
    chk("seq1_pc", o_pc, 16'h0001);
    chk("seq1_valid", {15'd0, o_valid}, 16'h0001);
    cyc(1, 0, 0, 16'h0, 0, 1, 16'h2222);
    chk("seq2_instr", o_instr, 16'h2222);
    chk("seq2_pc", o_pc, 16'h0002);
    cyc(1, 0, 0, 16'h0, 0, 1, 16'h3333);
    cyc(1, 0, 0, 16'h0, 0, 1, 16'h4444);
    cyc(1, 0, 0, 16'h0, 0, 1, 16'h5555);
    chk("seq_addr5", o_imemAddr, 16'h0005);

    // Redirect discards the data returned in the same cycle
    cyc(1, 0, 1, 16'h0040, 0, 1, 16'hDEAD);
    chk("br_addr", o_imemAddr, 16'h0040);
    chk("br_valid", {15'd0, o_valid}, 16'h0000);
    chk("br_instr", o_instr, NOP);
    cyc(1, 0, 0, 16'h0, 0, 1, 16'h4040);
    chk("br_fetch_instr", o_instr, 16'h4040);
    chk("br_fetch_pc", o_pc, 16'h0041);

    // Stall at PC 0010 holds everything
    cyc(1, 0, 1, 16'h000F, 0, 1, 16'h0);
    cyc(1, 0, 0, 16'h0, 0, 1, 16'hABCD);
    for (int i = 0; i < 3; i++) begin
      cyc(1, 1, 0, 16'h0, 0, 1, 16'hBEEF);
      chk("stall_addr", o_imemAddr, 16'h0010);
      chk("stall_instr", o_instr, 16'hABCD);
      chk("stall_valid", {15'd0, o_valid}, 16'h0001);
    end
    cyc(1, 0, 0, 16'h0, 0, 1, 16'h1010);
    chk("unstall_instr", o_instr, 16'h1010);
    chk("unstall_pc", o_pc, 16'h0011);

    // Memory wait then redirect during WAIT
    for (int i = 0; i < 2; i++) begin
      cyc(1, 0, 0, 16'h0, 0, 0, 16'h9999);
      chk("wait_valid", {15'd0, o_valid}, 16'h0000);
      chk("wait_addr", o_imemAddr, 16'h0011);
      chk("wait_instr", o_instr, NOP);
    end
    cyc(1, 0, 1, 16'h0100, 0, 0, 16'h0);
    chk("wait_br_addr", o_imemAddr, 16'h0100);
    cyc(1, 0, 0, 16'h0, 0, 1, 16'h0A0A);
    chk("wait_br_pc", o_pc, 16'h0101);

    // Halt, then redirect is ignored
    cyc(1, 0, 0, 16'h0, 1, 1, 16'h0);
    chk("halt_hlt", {15'd0, o_hlt}, 16'h0001);
    chk("halt_rd", {15'd0, o_imemRd}, 16'h0000);
    chk("halt_valid", {15'd0, o_valid}, 16'h0000);
    cyc(1, 0, 1, 16'h0300, 0, 1, 16'h0);
    chk("halt_br_addr", o_imemAddr, 16'h0101);
    chk("halt_br_hlt", {15'd0, o_hlt}, 16'h0001);
    cyc(0, 0, 0, 16'h0, 0, 1, 16'h0);
    cyc(1, 0, 1, 16'h0200, 1, 1, 16'h0);
    chk("brhlt_addr", o_imemAddr, 16'h0200);
    chk("brhlt_hlt", {15'd0, o_hlt}, 16'h0000);

    // PC wrap
    cyc(1, 0, 1, 16'hFFFF, 0, 1, 16'h0);
    cyc(1, 0, 0, 16'h0, 0, 1, 16'h7777);
    chk("wrap_pc", o_pc, 16'h0000);
    chk("wrap_addr", o_imemAddr, 16'h0000);
    chk("wrap_instr", o_instr, 16'h7777);

    // Reset in the middle of WAIT
    cyc(1, 0, 1, 16'h0055, 0, 1, 16'h0);
    cyc(1, 0, 0, 16'h0, 0, 1, 16'h3131);
    cyc(1, 0, 0, 16'h0, 0, 0, 16'h0);
    cyc(0, 1, 1, 16'h0777, 1, 0, 16'h0);
    chk("rstw_addr", o_imemAddr, 16'h0000);
    chk("rstw_instr", o_instr, NOP);
    chk("rstw_pc", o_pc, 16'h0000);
    chk("rstw_valid", {15'd0, o_valid}, 16'h0000);
    chk("rstw_hlt", {15'd0, o_hlt}, 16'h0000);

    for (int i = 0; i < 3; i++) cyc(1, 1, 0, 16'h0, 0, 1, 16'h0);
`ifdef IF_STALL_CNT_EN
    chk("stallcnt3", o_stallCnt, 16'h0003);
`endif

    // Randomized traffic
    for (int i = 0; i < 4000; i++) begin
      n = m_halt ? ($urandom_range(0, 7) != 0) : ($urandom_range(0, 99) != 0);
      b = ($urandom_range(0, 9) == 0);
      t = ($urandom_range(0, 7) == 0) ? 16'hFFFE : 16'($urandom);
      h = ($urandom_range(0, 39) == 0);
      s = ($urandom_range(0, 4) == 0);
      r = ($urandom_range(0, 3) != 0);
      cyc(n, s, b, t, h, r, 16'($urandom));
    end

    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
